sense_amp_latch: RTL

- Clocked, latching successor to the combinational differential sense-amp array of the mixed-signal SRAM read path.
- Sequences bitline precharge, a programmable bitline-develop window and a latched resolve across COLS columns.
- Enforces a minimum-differential margin and flags marginal columns.
- Presents both real-valued rail outputs (to the analog output model) and digital bits with a valid pulse (to the read-data path).

---
 rtl/sense_amp_latch.sv | 118 +++++++++++
 1 files changed

// File: rtl/sense_amp_latch.sv
// Clocked differential sense-amp array: precharge, timed bitline develop, then a
// latched resolve of every column with a minimum-differential margin flag.
`timescale 1ns/1ps
module sense_amp_latch #(
   parameter int  COLS       = 16,
   parameter int  PRE_CYCLES = 2,
   parameter int  DEV_CYCLES = 3,
   parameter real VDD        = 1.5,
   parameter real VSS        = 0.0,
   parameter real VMARGIN    = 0.1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sa_req,
   input  real             bl_rd  [0:COLS-1],
   input  real             blb_rd [0:COLS-1],
   output logic            precharge,
   output logic            sa_busy,
   output logic            rd_valid,
   output logic [COLS-1:0] dout,
   output real             preout [0:COLS-1],
   output logic [COLS-1:0] margin_err
);

   localparam int MAX_CYCLES = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;

   if (PRE_CYCLES < 1 || DEV_CYCLES < 1) begin : g_bad_params
      $error("sense_amp_latch: PRE_CYCLES and DEV_CYCLES must both be >= 1");
   end

   typedef enum logic [1:0] {IDLE, PRECH, DEVELOP, RESOLVE} state_t;

   state_t          state, next_state;
   logic [CW-1:0]   count, next_count;
   logic [COLS-1:0] bl_high, bl_small;

   always_comb begin
      next_state = state;
      next_count = count;
      case (state)
         IDLE: begin
            if (sa_req) begin
               next_state = PRECH;
               next_count = CW'(PRE_CYCLES - 1);
            end
         end
         PRECH: begin
            if (count == '0) begin
               next_state = DEVELOP;
               next_count = CW'(DEV_CYCLES - 1);
            end else begin
               next_count = count - CW'(1);
            end
         end
         DEVELOP: begin
            if (count == '0) begin
               next_state = RESOLVE;
            end else begin
               next_count = count - CW'(1);
            end
         end
         RESOLVE: begin
            next_state = IDLE;
            next_count = '0;
         end
         default: begin
            next_state = IDLE;
            next_count = '0;
         end
      endcase
   end

   // Precharge is registered from the next state so it is glitch-free and
   // covers exactly the PRECH cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         precharge <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         state     <= next_state;
         count     <= next_count;
         precharge <= (next_state == PRECH);
         rd_valid  <= (state == RESOLVE);
      end
   end

   assign sa_busy = (state != IDLE);

   // Equal bitlines resolve to 0; margin is checked symmetrically on |bl-blb|.
   always_comb begin
      bl_high  = '0;
      bl_small = '0;
      for (int i = 0; i < COLS; i++) begin
         bl_high[i]  = (bl_rd[i] > blb_rd[i]);
         bl_small[i] = ((bl_rd[i] - blb_rd[i]) < VMARGIN) && ((blb_rd[i] - bl_rd[i]) < VMARGIN);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         margin_err <= '0;
         for (int i = 0; i < COLS; i++) begin
            preout[i] <= VSS;
         end
      end else if (state == RESOLVE) begin
         dout       <= bl_high;
         margin_err <= bl_small;
         for (int i = 0; i < COLS; i++) begin
            preout[i] <= bl_high[i] ? VDD : VSS;
         end
      end
   end

endmodule
